// File: rtl/scs8hd_and4b_vecgen.sv
// Exhaustive vector generator and response checker for an and4b cell (X = !AN & B & C & D).
// Sweeps the 16 input codes LOOPS times, holding each code SETTLE+1 cycles, samples X on the
// last cycle of each hold and counts mismatches against the ideal and4b response.
//
// Ports:
//   CLK            clock, rising edge
//   RESETB         synchronous active-low reset
//   START          begin a run (ignored while BUSY)
//   X              output of the cell under test
//   AN, B, C, D    registered stimulus, code {AN,B,C,D}
//   BUSY           run in progress
//   DONE           one-cycle pulse when the run completes
//   PASS           last run saw no mismatch; valid from DONE until the next START
//   ERR_CNT        saturating mismatch count for the current/last run
//   FIRST_ERR_VLD  a mismatch has been seen since START
//   FIRST_ERR_VEC  code of the first mismatch
module scs8hd_and4b_vecgen #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOOPS  = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             START,
    input  logic             X,
    output logic             AN,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             FIRST_ERR_VLD,
    output logic [3:0]       FIRST_ERR_VEC
);

    typedef enum logic [1:0] {StIdle, StHold, StFin} state_e;

    localparam logic [3:0] IdleCode   = 4'b1000;
    localparam logic [3:0] LastCode   = 4'b1111;
    localparam logic [3:0] HitCode    = 4'b0111;  // only code where and4b drives 1
    localparam logic [3:0] SettleLast = 4'(SETTLE);
    localparam logic [7:0] LoopLast   = 8'(LOOPS - 1);

    state_e           state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [7:0]       loop_q, loop_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fvld_q, fvld_d;
    logic [3:0]       fvec_q, fvec_d;
    logic             pass_q, pass_d;
    logic             expect_x;
    logic             mismatch;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        loop_d   = loop_q;
        settle_d = settle_q;
        err_d    = err_q;
        fvld_d   = fvld_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        expect_x = (code_q == HitCode);
        mismatch = 1'b0;

        case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                code_d  = IdleCode;
                if (START) begin
                    state_d  = StHold;
                    code_d   = 4'b0000;
                    loop_d   = 8'd0;
                    settle_d = 4'd0;
                    err_d    = '0;
                    fvld_d   = 1'b0;
                    fvec_d   = 4'b0000;
                    pass_d   = 1'b0;
                end
            end
            StHold: begin
                if (settle_q == SettleLast) begin
                    // Case inequality so an X/Z response from the cell is flagged.
                    mismatch = (X !== expect_x);
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fvld_q) begin
                            fvld_d = 1'b1;
                            fvec_d = code_q;
                        end
                    end
                    if (code_q != LastCode) begin
                        code_d   = code_q + 1'b1;
                        settle_d = 4'd0;
                    end else if (loop_q < LoopLast) begin
                        code_d   = 4'b0000;
                        loop_d   = loop_q + 1'b1;
                        settle_d = 4'd0;
                    end else begin
                        state_d = StFin;
                        code_d  = IdleCode;
                        // Includes the final sample so PASS is already correct during DONE.
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                code_d  = IdleCode;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state_q  <= StIdle;
            code_q   <= IdleCode;
            loop_q   <= 8'd0;
            settle_q <= 4'd0;
            err_q    <= '0;
            fvld_q   <= 1'b0;
            fvec_q   <= 4'b0000;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            loop_q   <= loop_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fvld_q   <= fvld_d;
            fvec_q   <= fvec_d;
            pass_q   <= pass_d;
        end
    end

    assign {AN, B, C, D}  = code_q;
    assign BUSY           = (state_q == StHold);
    assign DONE           = (state_q == StFin);
    assign PASS           = pass_q;
    assign ERR_CNT        = err_q;
    assign FIRST_ERR_VLD  = fvld_q;
    assign FIRST_ERR_VEC  = fvec_q;

endmodule

// File: tb/tb_scs8hd_and4b_vecgen.sv
// Directed bench for scs8hd_and4b_vecgen. Three instances:
//   u0: SETTLE=2, LOOPS=1, CNT_W=8, cell model selectable (ideal/stuck0/stuck1/2-cycle lag)
//   u1: SETTLE=1, LOOPS=1, CNT_W=8, 2-cycle lag cell model
//   u2: SETTLE=2, LOOPS=3, CNT_W=4, stuck-at-1 cell
module tb_scs8hd_and4b_vecgen;

    logic       clk;
    logic       rstb;
    logic [2:0] start;
    logic [2:0] x;
    logic [2:0] an, b, c, d, busy, done, pass, fvld;
    logic [3:0] fvec [3];
    logic [7:0] err  [3];
    logic [3:0] err2_raw;
    logic [1:0] r1, r2;
    int         mode0;
    int         total;
    int         bad;
    int         bcyc;
    int         npulse;
    bit         tmo;
    bit         found;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scs8hd_and4b_vecgen #(.SETTLE(2), .LOOPS(1), .CNT_W(8)) u0 (
        .CLK(clk), .RESETB(rstb), .START(start[0]), .X(x[0]),
        .AN(an[0]), .B(b[0]), .C(c[0]), .D(d[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err[0]),
        .FIRST_ERR_VLD(fvld[0]), .FIRST_ERR_VEC(fvec[0])
    );

    scs8hd_and4b_vecgen #(.SETTLE(1), .LOOPS(1), .CNT_W(8)) u1 (
        .CLK(clk), .RESETB(rstb), .START(start[1]), .X(x[1]),
        .AN(an[1]), .B(b[1]), .C(c[1]), .D(d[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err[1]),
        .FIRST_ERR_VLD(fvld[1]), .FIRST_ERR_VEC(fvec[1])
    );

    scs8hd_and4b_vecgen #(.SETTLE(2), .LOOPS(3), .CNT_W(4)) u2 (
        .CLK(clk), .RESETB(rstb), .START(start[2]), .X(x[2]),
        .AN(an[2]), .B(b[2]), .C(c[2]), .D(d[2]),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err2_raw),
        .FIRST_ERR_VLD(fvld[2]), .FIRST_ERR_VEC(fvec[2])
    );

    assign err[2] = {4'b0000, err2_raw};

    // Cell models: ideal and4b, and a version delayed by two flops.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            r1[i] <= ~an[i] & b[i] & c[i] & d[i];
            r2[i] <= r1[i];
        end
    end

    always_comb begin
        case (mode0)
            1:       x[0] = 1'b0;
            2:       x[0] = 1'b1;
            3:       x[0] = r2[0];
            default: x[0] = ~an[0] & b[0] & c[0] & d[0];
        endcase
        x[1] = r2[1];
        x[2] = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from the current cycle until DONE is seen; counts BUSY cycles on the way.
    // Optionally pulses START on iteration pulse_at (to show it is ignored).
    task automatic wait_done(input int i, input int budget, input int pulse_at,
                             output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int k = 0; k < budget; k++) begin
            start[i] = (k == pulse_at);
            if (done[i]) begin
                start[i]  = 1'b0;
                timed_out = 1'b0;
                break;
            end
            if (busy[i]) busy_cycles++;
            tick();
        end
        start[i] = 1'b0;
    endtask

    task automatic run(input int i, input int budget, input int pulse_at,
                       output int busy_cycles, output bit timed_out);
        tick();
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        wait_done(i, budget, pulse_at, busy_cycles, timed_out);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mode0 = 0;
        start = 3'b000;
        rstb  = 1'b0;
        repeat (4) tick();

        // Reset state
        chk("rst_code", {an[0], b[0], c[0], d[0]}, 4'b1000);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_pass", pass[0], 1'b0);
        chk("rst_err", err[0], 8'd0);
        chk("rst_fvld", fvld[0], 1'b0);
        chk("rst_fvec", fvec[0], 4'd0);
        rstb = 1'b1;
        repeat (3) tick();

        // Ideal cell
        mode0 = 0;
        run(0, 200, -1, bcyc, tmo);
        chk("ideal_tmo", tmo, 1'b0);
        chk("ideal_busy_len", bcyc, 48);
        chk("ideal_busy_at_done", busy[0], 1'b0);
        chk("ideal_pass", pass[0], 1'b1);
        chk("ideal_err", err[0], 8'd0);
        chk("ideal_fvld", fvld[0], 1'b0);
        chk("ideal_fin_code", {an[0], b[0], c[0], d[0]}, 4'b1000);
        tick();
        chk("ideal_done_one_cycle", done[0], 1'b0);
        chk("ideal_pass_hold", pass[0], 1'b1);

        // Stuck-at-0
        mode0 = 1;
        run(0, 200, -1, bcyc, tmo);
        chk("sa0_tmo", tmo, 1'b0);
        chk("sa0_err", err[0], 8'd1);
        chk("sa0_fvld", fvld[0], 1'b1);
        chk("sa0_fvec", fvec[0], 4'b0111);
        chk("sa0_pass", pass[0], 1'b0);

        // Stuck-at-1
        mode0 = 2;
        run(0, 200, -1, bcyc, tmo);
        chk("sa1_tmo", tmo, 1'b0);
        chk("sa1_err", err[0], 8'd15);
        chk("sa1_fvec", fvec[0], 4'b0000);
        chk("sa1_pass", pass[0], 1'b0);

        // 2-cycle lag with SETTLE=2 is absorbed
        mode0 = 3;
        run(0, 200, -1, bcyc, tmo);
        chk("lag2_tmo", tmo, 1'b0);
        chk("lag2_pass", pass[0], 1'b1);
        chk("lag2_err", err[0], 8'd0);

        // 2-cycle lag with SETTLE=1 misses codes 7 and 8
        run(1, 200, -1, bcyc, tmo);
        chk("lag1_tmo", tmo, 1'b0);
        chk("lag1_busy_len", bcyc, 32);
        chk("lag1_err", err[1], 8'd2);
        chk("lag1_fvec", fvec[1], 4'b0111);
        chk("lag1_pass", pass[1], 1'b0);

        // Saturation over 3 loops with a 4-bit counter
        run(2, 400, -1, bcyc, tmo);
        chk("sat_tmo", tmo, 1'b0);
        chk("sat_busy_len", bcyc, 144);
        chk("sat_err", err[2], 8'd15);
        chk("sat_fvec", fvec[2], 4'b0000);
        chk("sat_pass", pass[2], 1'b0);

        // START while BUSY is ignored
        mode0 = 0;
        run(0, 200, 10, bcyc, tmo);
        chk("busy_start_tmo", tmo, 1'b0);
        chk("busy_start_len", bcyc, 48);
        chk("busy_start_pass", pass[0], 1'b1);

        // START held through FIN restarts immediately with counters cleared
        mode0 = 2;
        run(0, 200, -1, bcyc, tmo);
        chk("b2b_first_err", err[0], 8'd15);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("b2b_busy", busy[0], 1'b1);
        chk("b2b_done", done[0], 1'b0);
        chk("b2b_err_clr", err[0], 8'd0);
        chk("b2b_fvld_clr", fvld[0], 1'b0);
        chk("b2b_code", {an[0], b[0], c[0], d[0]}, 4'b0000);
        wait_done(0, 200, -1, bcyc, tmo);
        chk("b2b_tmo", tmo, 1'b0);
        chk("b2b_len", bcyc, 48);
        chk("b2b_err", err[0], 8'd15);

        // Reset mid-run at code 5
        mode0 = 2;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if ({an[0], b[0], c[0], d[0]} == 4'b0101) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_found", found, 1'b1);
        chk("mid_err_before", err[0], 8'd5);
        rstb = 1'b0;
        tick();
        chk("mid_code", {an[0], b[0], c[0], d[0]}, 4'b1000);
        chk("mid_busy", busy[0], 1'b0);
        chk("mid_err", err[0], 8'd0);
        chk("mid_fvld", fvld[0], 1'b0);
        rstb = 1'b1;
        npulse = 0;
        for (int k = 0; k < 60; k++) begin
            if (done[0] || busy[0]) npulse++;
            tick();
        end
        chk("mid_no_done", npulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
